// File: rtl/knight_pkg.sv
// ============================================================================
// Module   : knight_pkg
// Brief    : Shared types and key codes for the Knight motion block.
// Revision : 1.0
// ============================================================================
`default_nettype none

package knight_pkg;

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_AIR    = 2'd1,
        ST_DASH   = 2'd2
    } state_t;

    localparam logic [7:0] c_KEY_LEFT  = 8'h04;
    localparam logic [7:0] c_KEY_RIGHT = 8'h07;
    localparam logic [7:0] c_KEY_JUMP  = 8'h1A;
    localparam logic [7:0] c_KEY_SPACE = 8'h2C;
    localparam logic [7:0] c_KEY_DASH  = 8'h0D;

    typedef logic signed [7:0]  vel_t;
    typedef logic signed [11:0] coord_t;

endpackage

`default_nettype wire

// File: rtl/vsync_tick.sv
// ============================================================================
// Module   : vsync_tick
// Brief    : Synchronises vertical sync and emits a one-clock frame tick.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vsync_tick (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_frame_clk,
    output logic o_tick
);

    logic r_sync1;
    logic r_sync2;
    logic r_sync3;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= i_frame_clk;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign o_tick = r_sync2 & ~r_sync3;

endmodule

`default_nettype wire

// File: rtl/knight_motion.sv
// ============================================================================
// Module   : knight_motion
// Brief    : Frame-rate platformer physics (walk, jump, air dash, clamping).
// Revision : 1.0
// ============================================================================
`default_nettype none

module knight_motion
    import knight_pkg::*;
#(
    parameter int SCREEN_W    = 640,
    parameter int GROUND_Y    = 400,
    parameter int SIZE_X      = 16,
    parameter int SIZE_Y      = 24,
    parameter int WALK_STEP   = 2,
    parameter int GRAVITY     = 1,
    parameter int JUMP_VEL    = 12,
    parameter int MAX_FALL    = 8,
    parameter int JUMP_CUT    = 2,
    parameter int DASH_STEP   = 6,
    parameter int DASH_FRAMES = 8,
    parameter int NKEYS       = 6
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic [8*NKEYS-1:0] keycode,
    output logic [9:0]         PosX,
    output logic [9:0]         PosY,
    output logic [9:0]         SizeX,
    output logic [9:0]         SizeY,
    output logic               Facing,
    output logic [1:0]         State
);

    localparam int     c_DCW      = (DASH_FRAMES > 1) ? $clog2(DASH_FRAMES) : 1;
    localparam coord_t c_X_MAX    = coord_t'(SCREEN_W - SIZE_X);
    localparam coord_t c_Y_GROUND = coord_t'(GROUND_Y - SIZE_Y);
    localparam logic [9:0] c_X_HOME = 10'((SCREEN_W - SIZE_X) / 2);
    localparam vel_t   c_VY_JUMP  = vel_t'(-JUMP_VEL);
    localparam vel_t   c_VY_CUT   = vel_t'(-JUMP_CUT);
    localparam vel_t   c_VY_MAX   = vel_t'(MAX_FALL);
    localparam vel_t   c_VY_G     = vel_t'(GRAVITY);

    logic             w_tick;
    state_t           r_state, w_state_nx;
    vel_t             r_vy, w_vy_nx, w_vy_fall;
    logic [9:0]       r_pos_x, r_pos_y, w_pos_x_nx, w_pos_y_nx;
    logic             r_facing, w_facing_nx;
    logic             r_dash_avail, w_avail_nx;
    logic [c_DCW-1:0] r_dash_cnt, w_cnt_nx;
    logic             r_prev_jump, r_prev_dash;
    logic             w_left, w_right, w_jump, w_dash;
    logic             w_jump_edge, w_dash_edge;
    coord_t           w_x_cur, w_y_cur, w_x_cand, w_y_cand;

    vsync_tick u_vsync_tick (
        .i_clk       (Clk),
        .i_rst       (Reset),
        .i_frame_clk (frame_clk),
        .o_tick      (w_tick)
    );

    always_comb begin
        w_left  = 1'b0;
        w_right = 1'b0;
        w_jump  = 1'b0;
        w_dash  = 1'b0;
        for (int k = 0; k < NKEYS; k++) begin
            if (keycode[8*k +: 8] == c_KEY_LEFT)  w_left  = 1'b1;
            if (keycode[8*k +: 8] == c_KEY_RIGHT) w_right = 1'b1;
            if (keycode[8*k +: 8] == c_KEY_JUMP ||
                keycode[8*k +: 8] == c_KEY_SPACE) w_jump = 1'b1;
            if (keycode[8*k +: 8] == c_KEY_DASH)  w_dash  = 1'b1;
        end
    end

    assign w_jump_edge = w_jump & ~r_prev_jump;
    assign w_dash_edge = w_dash & ~r_prev_dash;
    assign w_x_cur     = coord_t'({2'b00, r_pos_x});
    assign w_y_cur     = coord_t'({2'b00, r_pos_y});

    always_comb begin
        w_state_nx  = r_state;
        w_vy_nx     = r_vy;
        w_facing_nx = r_facing;
        w_avail_nx  = r_dash_avail;
        w_cnt_nx    = r_dash_cnt;
        w_x_cand    = w_x_cur;
        w_y_cand    = w_y_cur;
        w_pos_x_nx  = r_pos_x;
        w_pos_y_nx  = r_pos_y;

        w_vy_fall = r_vy + c_VY_G;
        if (w_vy_fall > c_VY_MAX) w_vy_fall = c_VY_MAX;

        if (r_state != ST_DASH) begin
            if (w_left && !w_right) begin
                w_x_cand    = w_x_cur - coord_t'(WALK_STEP);
                w_facing_nx = 1'b0;
            end else if (w_right && !w_left) begin
                w_x_cand    = w_x_cur + coord_t'(WALK_STEP);
                w_facing_nx = 1'b1;
            end
        end

        case (r_state)
            ST_GROUND: begin
                if (w_dash_edge && r_dash_avail) begin
                    w_state_nx = ST_DASH;
                    w_avail_nx = 1'b0;
                    w_cnt_nx   = '0;
                end else if (w_jump_edge) begin
                    w_vy_nx    = c_VY_JUMP;
                    w_state_nx = ST_AIR;
                end
            end
            ST_AIR: begin
                w_y_cand = w_y_cur + coord_t'(r_vy);
                w_vy_nx  = w_vy_fall;
                if (!w_jump && w_vy_fall < c_VY_CUT) w_vy_nx = c_VY_CUT;
                if (w_dash_edge && r_dash_avail) begin
                    w_state_nx = ST_DASH;
                    w_avail_nx = 1'b0;
                    w_cnt_nx   = '0;
                end
                // Touching the floor overrides any dash request on the same tick
                if (w_y_cand >= c_Y_GROUND) begin
                    w_y_cand   = c_Y_GROUND;
                    w_vy_nx    = '0;
                    w_state_nx = ST_GROUND;
                    w_avail_nx = 1'b1;
                end else if (w_y_cand < coord_t'(0)) begin
                    w_y_cand = '0;
                    w_vy_nx  = '0;
                end
            end
            ST_DASH: begin
                w_x_cand = r_facing ? (w_x_cur + coord_t'(DASH_STEP))
                                    : (w_x_cur - coord_t'(DASH_STEP));
                w_vy_nx  = '0;
                w_cnt_nx = r_dash_cnt + c_DCW'(1);
                if (r_dash_cnt == c_DCW'(DASH_FRAMES - 1)) begin
                    w_cnt_nx = '0;
                    if (w_y_cur == c_Y_GROUND) begin
                        w_state_nx = ST_GROUND;
                        w_avail_nx = 1'b1;
                    end else begin
                        w_state_nx = ST_AIR;
                    end
                end
            end
            default: w_state_nx = ST_GROUND;
        endcase

        if (w_x_cand < coord_t'(0))  w_pos_x_nx = '0;
        else if (w_x_cand > c_X_MAX) w_pos_x_nx = c_X_MAX[9:0];
        else                         w_pos_x_nx = w_x_cand[9:0];
        w_pos_y_nx = w_y_cand[9:0];
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= ST_GROUND;
            r_vy         <= '0;
            r_pos_x      <= c_X_HOME;
            r_pos_y      <= c_Y_GROUND[9:0];
            r_facing     <= 1'b1;
            r_dash_avail <= 1'b1;
            r_dash_cnt   <= '0;
            r_prev_jump  <= 1'b0;
            r_prev_dash  <= 1'b0;
        end else if (w_tick) begin
            r_state      <= w_state_nx;
            r_vy         <= w_vy_nx;
            r_pos_x      <= w_pos_x_nx;
            r_pos_y      <= w_pos_y_nx;
            r_facing     <= w_facing_nx;
            r_dash_avail <= w_avail_nx;
            r_dash_cnt   <= w_cnt_nx;
            r_prev_jump  <= w_jump;
            r_prev_dash  <= w_dash;
        end
    end

    assign PosX   = r_pos_x;
    assign PosY   = r_pos_y;
    assign SizeX  = 10'(SIZE_X);
    assign SizeY  = 10'(SIZE_Y);
    assign Facing = r_facing;
    assign State  = r_state;

endmodule

`default_nettype wire
